// File: rtl/bus_control_sequencer.sv
// rtl/bus_control_sequencer.sv - multi-cycle bus/ALU control sequencer
// Fetches one instruction per EXEC and strobes register, A/G and bus controls over 1-3 cycles.
module bus_control_sequencer #(
    parameter int N = 10
) (
    input  logic         CLKb,
    input  logic         RST,
    input  logic         EXEC,
    input  logic [N-1:0] INSTR,
    output logic [3:0]   Rout,
    output logic [3:0]   Rin,
    output logic         IRout,
    output logic         Ain,
    output logic         Gin,
    output logic         Gout,
    output logic [3:0]   FN,
    output logic         BUSY,
    output logic         DONE,
    output logic         ILL
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t       state;
    logic [N-1:0] ir;

    logic [1:0] cls;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] fn_field;
    logic       fn_legal;
    logic       single_cycle;

    assign cls      = ir[9:8];
    assign rx       = ir[7:6];
    assign fn_field = ir[5:2];
    assign ry       = ir[1:0];
    assign fn_legal = (fn_field >= 4'd2) && (fn_field <= 4'd11);
    // MOV and illegal reg-reg ops finish in T1; everything else runs T1..T3.
    assign single_cycle = (cls == 2'b01) || ((cls == 2'b00) && !fn_legal);

    always_ff @(negedge CLKb) begin
        if (RST) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EXEC) begin
                        ir    <= INSTR;
                        state <= T1;
                    end
                end
                T1:      state <= single_cycle ? IDLE : T2;
                T2:      state <= T3;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Rout  = 4'b0000;
        Rin   = 4'b0000;
        IRout = 1'b0;
        Ain   = 1'b0;
        Gin   = 1'b0;
        Gout  = 1'b0;
        FN    = 4'b0000;
        BUSY  = (state != IDLE);
        DONE  = 1'b0;
        ILL   = 1'b0;
        case (state)
            T1: begin
                if (cls == 2'b01) begin
                    Rout = 4'b0001 << ry;
                    Rin  = 4'b0001 << rx;
                    DONE = 1'b1;
                end else if (single_cycle) begin
                    DONE = 1'b1;
                    ILL  = 1'b1;
                end else begin
                    Rout = 4'b0001 << rx;
                    Ain  = 1'b1;
                end
            end
            T2: begin
                Gin = 1'b1;
                if (cls == 2'b00) begin
                    Rout = 4'b0001 << ry;
                    FN   = fn_field;
                end else begin
                    // Immediate ops: the ALU decodes class and imm straight off the bus.
                    IRout = 1'b1;
                end
            end
            T3: begin
                Gout = 1'b1;
                Rin  = 4'b0001 << rx;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// tb/tb_bus_control_sequencer.sv - scoreboard bench for bus_control_sequencer
// Expected control vectors are queued with each stimulus step and popped after the falling edge.
module tb_bus_control_sequencer;

    logic       CLKb;
    logic       RST;
    logic       EXEC;
    logic [9:0] INSTR;
    logic [3:0] Rout;
    logic [3:0] Rin;
    logic       IRout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [3:0] FN;
    logic       BUSY;
    logic       DONE;
    logic       ILL;

    int checks = 0;
    int errors = 0;

    bus_control_sequencer #(.N(10)) dut (
        .CLKb  (CLKb),
        .RST   (RST),
        .EXEC  (EXEC),
        .INSTR (INSTR),
        .Rout  (Rout),
        .Rin   (Rin),
        .IRout (IRout),
        .Ain   (Ain),
        .Gin   (Gin),
        .Gout  (Gout),
        .FN    (FN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ILL   (ILL)
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    logic [18:0] obs;
    assign obs = {BUSY, DONE, ILL, Rout, Rin, IRout, Ain, Gin, Gout, FN};

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    exp_t exp_q[$];

    // Small register-file/ALU model driven by the sequencer's strobes.
    logic [9:0] regs [4];
    logic [9:0] a_reg = '0;
    logic [9:0] g_reg = '0;
    logic [9:0] model_ir = '0;
    logic [9:0] bus;

    always @(negedge CLKb) begin
        bus = '0;
        for (int i = 0; i < 4; i++) if (Rout[i]) bus = regs[i];
        if (IRout) bus = model_ir;
        if (Gout)  bus = g_reg;
        if (Gin) begin
            if (FN == 4'b0000)
                g_reg = (bus[9:8] == 2'b10) ? a_reg + {4'b0, bus[5:0]} : a_reg - {4'b0, bus[5:0]};
            else if (FN == 4'b0011)
                g_reg = a_reg - bus;
            else
                g_reg = a_reg + bus;
        end
        a_reg = Ain ? bus : '0;
        for (int i = 0; i < 4; i++) if (Rin[i]) regs[i] = bus;
        if (!RST && !BUSY && EXEC) model_ir = INSTR;
    end

    function automatic logic [18:0] ev(input logic busy, input logic done, input logic ill,
                                       input logic [3:0] rout, input logic [3:0] rin,
                                       input logic irout, input logic ain, input logic gin,
                                       input logic gout, input logic [3:0] fn);
        return {busy, done, ill, rout, rin, irout, ain, gin, gout, fn};
    endfunction

    task automatic step(input logic rst, input logic exec, input logic [9:0] instr,
                        input string tag, input logic [18:0] e);
        exp_t x;
        exp_t got;
        int   drivers;
        RST   = rst;
        EXEC  = exec;
        INSTR = instr;
        x.tag = tag;
        x.v   = e;
        exp_q.push_back(x);
        @(negedge CLKb);
        #1;
        got = exp_q.pop_front();
        checks++;
        assert (obs === got.v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", got.tag, obs, got.v);
        end
        drivers = int'(IRout) + int'(Gout) + int'(Rout != 4'b0000);
        checks++;
        assert (drivers <= 1 && (!ILL || DONE)) else begin
            errors++;
            $error("FAIL %s_invariant: observed drivers=%0d ill=%b done=%b expected drivers<=1 and ill only with done",
                   got.tag, drivers, ILL, DONE);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [9:0] e);
        checks++;
        assert (regs[idx] === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, regs[idx], e);
        end
    endtask

    localparam logic [18:0] ZERO = 19'd0;

    initial begin
        regs[0] = 10'd0;
        regs[1] = 10'd3;
        regs[2] = 10'd4;
        regs[3] = 10'd7;
        RST = 1'b1; EXEC = 1'b1; INSTR = 10'h04A;

        step(1, 1, 10'h04A, "reset0", ZERO);
        step(1, 1, 10'h04A, "reset1", ZERO);

        // ADD R1,R2
        step(0, 1, 10'h04A, "add_t1", ev(1, 0, 0, 4'b0010, 4'b0000, 0, 1, 0, 0, 4'b0000));
        step(0, 0, 10'h000, "add_t2", ev(1, 0, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0010));
        step(0, 0, 10'h000, "add_t3", ev(1, 1, 0, 4'b0000, 4'b0010, 0, 0, 0, 1, 4'b0000));
        step(0, 0, 10'h000, "add_idle", ZERO);
        check_reg("add_r1", 1, 10'd7);

        // ADDI R3,#5
        step(0, 1, 10'h2C5, "addi_t1", ev(1, 0, 0, 4'b1000, 4'b0000, 0, 1, 0, 0, 4'b0000));
        step(0, 0, 10'h000, "addi_t2", ev(1, 0, 0, 4'b0000, 4'b0000, 1, 0, 1, 0, 4'b0000));
        step(0, 0, 10'h000, "addi_t3", ev(1, 1, 0, 4'b0000, 4'b1000, 0, 0, 0, 1, 4'b0000));
        step(0, 0, 10'h000, "addi_idle", ZERO);
        check_reg("addi_r3", 3, 10'd12);

        // MOV R0,R3
        step(0, 1, 10'h103, "mov_t1", ev(1, 1, 0, 4'b1000, 4'b0001, 0, 0, 0, 0, 4'b0000));
        step(0, 0, 10'h000, "mov_idle", ZERO);
        check_reg("mov_r0", 0, 10'd12);

        // Illegal FN=1111
        step(0, 1, 10'h03C, "ill_t1", ev(1, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000));
        step(0, 0, 10'h000, "ill_idle", ZERO);

        // EXEC held while busy must not disturb the running ADD
        step(0, 1, 10'h04A, "busy_t1", ev(1, 0, 0, 4'b0010, 4'b0000, 0, 1, 0, 0, 4'b0000));
        step(0, 1, 10'h103, "busy_t2", ev(1, 0, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0010));
        step(0, 1, 10'h103, "busy_t3", ev(1, 1, 0, 4'b0000, 4'b0010, 0, 0, 0, 1, 4'b0000));
        step(0, 1, 10'h103, "busy_idle", ZERO);
        step(0, 1, 10'h103, "busy_mov", ev(1, 1, 0, 4'b1000, 4'b0001, 0, 0, 0, 0, 4'b0000));
        step(0, 0, 10'h000, "busy_done_idle", ZERO);
        check_reg("busy_r1", 1, 10'd11);

        // Reset in T2 aborts the ADD before any Rin
        step(0, 1, 10'h04A, "rst_t1", ev(1, 0, 0, 4'b0010, 4'b0000, 0, 1, 0, 0, 4'b0000));
        step(0, 0, 10'h000, "rst_t2", ev(1, 0, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0010));
        step(1, 0, 10'h000, "rst_abort", ZERO);
        step(0, 0, 10'h000, "rst_after0", ZERO);
        step(0, 0, 10'h000, "rst_after1", ZERO);
        check_reg("rst_r1_kept", 1, 10'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
